// File: rtl/opl3_pkg.sv
// Shared widths, register map constants, FSM encodings and payload structs
// for the OPL3 host register front end.
package opl3_pkg;

  localparam int unsigned REG_FNUM_WIDTH  = 10;
  localparam int unsigned REG_BLOCK_WIDTH = 3;
  localparam int unsigned REG_MULT_WIDTH  = 4;
  localparam int unsigned REG_WS_WIDTH    = 3;

  localparam int unsigned OPL3_NUM_OPS        = 36;
  localparam int unsigned OPL3_NUM_CHANS      = 18;
  localparam int unsigned OPL3_OPS_PER_BANK   = 18;
  localparam int unsigned OPL3_CHANS_PER_BANK = 9;

  localparam int unsigned SLOT_W = 6;
  localparam int unsigned CHAN_W = 5;

  // Register base addresses
  localparam logic [7:0] ADDR_OP_AM  = 8'h20;
  localparam logic [7:0] ADDR_CH_FLO = 8'hA0;
  localparam logic [7:0] ADDR_CH_FHI = 8'hB0;
  localparam logic [7:0] ADDR_DVB    = 8'hBD;
  localparam logic [7:0] ADDR_OP_WS  = 8'hE0;
  localparam logic [7:0] ADDR_NEW    = 8'h05;

  // Data-write pipeline states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // What a committed data write updates
  typedef enum logic [2:0] {
    DK_NONE  = 3'd0,
    DK_OP_AM = 3'd1,
    DK_OP_WS = 3'd2,
    DK_CH_A  = 3'd3,
    DK_CH_B  = 3'd4,
    DK_DVB   = 3'd5,
    DK_NEW   = 3'd6
  } dec_kind_t;

  typedef struct packed {
    logic                      vib;
    logic [REG_MULT_WIDTH-1:0] mult;
    logic [REG_WS_WIDTH-1:0]   ws;
  } op_regs_t;

  typedef struct packed {
    logic [REG_FNUM_WIDTH-1:0]  fnum;
    logic [REG_BLOCK_WIDTH-1:0] block;
  } chan_regs_t;

endpackage

// File: rtl/opl3_reg_decode_if.sv
// Host write bus and indexed operator read port of the register front end.
interface opl3_reg_decode_if;
  import opl3_pkg::*;

  logic                       host_wr;
  logic                       host_a0;
  logic                       host_a1;
  logic [7:0]                 host_din;
  logic                       host_busy;
  logic                       host_drop;
  logic [SLOT_W-1:0]          op_sel;
  logic [REG_FNUM_WIDTH-1:0]  fnum;
  logic [REG_BLOCK_WIDTH-1:0] block;
  logic [REG_MULT_WIDTH-1:0]  mult;
  logic [REG_WS_WIDTH-1:0]    ws;
  logic                       vib;
  logic                       dvb;

  modport master (
    output host_wr, host_a0, host_a1, host_din, op_sel,
    input  host_busy, host_drop, fnum, block, mult, ws, vib, dvb
  );

  modport slave (
    input  host_wr, host_a0, host_a1, host_din, op_sel,
    output host_busy, host_drop, fnum, block, mult, ws, vib, dvb
  );

endinterface

// File: rtl/opl3_slot_map.sv
// Combinational OPL3 slot arithmetic: register offset -> operator slot, and
// operator slot -> owning channel.
module opl3_slot_map
  import opl3_pkg::*;
(
  input  logic              bank_i,
  input  logic [4:0]        off_i,
  input  logic [SLOT_W-1:0] slot_i,
  output logic              op_valid_c_o,
  output logic [SLOT_W-1:0] op_slot_c_o,
  output logic [CHAN_W-1:0] chan_c_o
);

  localparam logic [SLOT_W-1:0] OPS_BANK   = SLOT_W'(OPL3_OPS_PER_BANK);
  localparam logic [CHAN_W-1:0] CHANS_BANK = CHAN_W'(OPL3_CHANS_PER_BANK);

  logic       hi_c;
  logic [4:0] rem_c;
  logic [1:0] grp_c;
  logic [2:0] pos_c;
  logic [1:0] sub_c;

  // Offsets come in groups of 8 with the top two of each group unused
  always_comb begin
    op_valid_c_o = (off_i <= 5'd21) && (off_i[2:0] < 3'd6);
    op_slot_c_o  = (bank_i ? OPS_BANK : '0)
                 + SLOT_W'(off_i[4:3]) * SLOT_W'(6)
                 + SLOT_W'(off_i[2:0]);
  end

  // Each group of 6 slots holds 3 channels, two operators per channel
  always_comb begin
    hi_c  = (slot_i >= OPS_BANK);
    rem_c = hi_c ? 5'(slot_i - OPS_BANK) : 5'(slot_i);
    if (rem_c >= 5'd12) begin
      grp_c = 2'd2;
      pos_c = 3'(rem_c - 5'd12);
    end else if (rem_c >= 5'd6) begin
      grp_c = 2'd1;
      pos_c = 3'(rem_c - 5'd6);
    end else begin
      grp_c = 2'd0;
      pos_c = 3'(rem_c);
    end
    sub_c    = (pos_c >= 3'd3) ? 2'(pos_c - 3'd3) : 2'(pos_c);
    chan_c_o = (hi_c ? CHANS_BANK : '0)
             + CHAN_W'(grp_c) * CHAN_W'(3)
             + CHAN_W'(sub_c);
  end

endmodule

// File: rtl/opl3_reg_decode.sv
// OPL3 host register front end: two-phase host writes are decoded into
// per-operator and per-channel storage, served through a registered read port.
module opl3_reg_decode
  import opl3_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES = 4,
  parameter int unsigned NUM_OPS     = OPL3_NUM_OPS,
  parameter int unsigned NUM_CHANS   = OPL3_NUM_CHANS
) (
  input  logic             clk,
  input  logic             reset_n,
  opl3_reg_decode_if.slave bus
);

  localparam int unsigned HOLD_W = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

  logic [1:0]          state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                busy_q, busy_d;
  logic                drop_q, drop_d;
  logic [7:0]          addr0_q, addr1_q;
  logic                cap_bank_q;
  logic [7:0]          cap_addr_q;
  logic [7:0]          cap_din_q;
  dec_kind_t           dec_kind_q, dec_kind_d;
  logic [SLOT_W-1:0]   dec_idx_q, dec_idx_d;
  logic                new_q;
  logic                dvb_q;
  op_regs_t            op_q [NUM_OPS];
  chan_regs_t          ch_q [NUM_CHANS];

  logic [REG_FNUM_WIDTH-1:0]  fnum_q;
  logic [REG_BLOCK_WIDTH-1:0] block_q;
  logic [REG_MULT_WIDTH-1:0]  mult_q;
  logic [REG_WS_WIDTH-1:0]    ws_q;
  logic                       vib_q;

  logic              data_wr_c, addr_wr_c, accept_c;
  logic              op_valid_c;
  logic [SLOT_W-1:0] op_slot_c;
  logic [CHAN_W-1:0] rd_chan_c;

  assign data_wr_c = bus.host_wr &  bus.host_a0;
  assign addr_wr_c = bus.host_wr & ~bus.host_a0;
  assign accept_c  = data_wr_c && (state_q == ST_IDLE);

  opl3_slot_map u_slot_map (
    .bank_i       (cap_bank_q),
    .off_i        (cap_addr_q[4:0]),
    .slot_i       (bus.op_sel),
    .op_valid_c_o (op_valid_c),
    .op_slot_c_o  (op_slot_c),
    .chan_c_o     (rd_chan_c)
  );

  // FSM state, hold counter and host status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  // Next state: IDLE -> DECODE -> COMMIT -> BUSY_CYCLES x HOLD -> IDLE
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE:   if (data_wr_c) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_COMMIT;
      ST_COMMIT: begin
        state_d = ST_HOLD;
        hold_d  = HOLD_W'(BUSY_CYCLES - 1);
      end
      ST_HOLD: begin
        if (hold_q == '0) state_d = ST_IDLE;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      default:   state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    drop_d = data_wr_c && (state_q != ST_IDLE);
  end

  // Classify the captured write into the register it targets
  always_comb begin
    dec_kind_d = DK_NONE;
    dec_idx_d  = '0;
    if ((cap_addr_q[7:5] == ADDR_OP_AM[7:5]) && op_valid_c) begin
      dec_kind_d = DK_OP_AM;
      dec_idx_d  = op_slot_c;
    end else if ((cap_addr_q[7:5] == ADDR_OP_WS[7:5]) && op_valid_c) begin
      dec_kind_d = DK_OP_WS;
      dec_idx_d  = op_slot_c;
    end else if ((cap_addr_q[7:4] == ADDR_CH_FLO[7:4]) && (cap_addr_q[3:0] <= 4'd8)) begin
      dec_kind_d = DK_CH_A;
      dec_idx_d  = SLOT_W'((cap_bank_q ? CHAN_W'(OPL3_CHANS_PER_BANK) : '0)
                           + CHAN_W'(cap_addr_q[3:0]));
    end else if ((cap_addr_q[7:4] == ADDR_CH_FHI[7:4]) && (cap_addr_q[3:0] <= 4'd8)) begin
      dec_kind_d = DK_CH_B;
      dec_idx_d  = SLOT_W'((cap_bank_q ? CHAN_W'(OPL3_CHANS_PER_BANK) : '0)
                           + CHAN_W'(cap_addr_q[3:0]));
    end else if (!cap_bank_q && (cap_addr_q == ADDR_DVB)) begin
      dec_kind_d = DK_DVB;
    end else if (cap_bank_q && (cap_addr_q == ADDR_NEW)) begin
      dec_kind_d = DK_NEW;
    end
  end

  // Address latches, write capture and decode result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr0_q    <= '0;
      addr1_q    <= '0;
      cap_bank_q <= 1'b0;
      cap_addr_q <= '0;
      cap_din_q  <= '0;
      dec_kind_q <= DK_NONE;
      dec_idx_q  <= '0;
    end else begin
      if (addr_wr_c) begin
        if (bus.host_a1) addr1_q <= bus.host_din;
        else             addr0_q <= bus.host_din;
      end
      if (accept_c) begin
        cap_bank_q <= bus.host_a1;
        cap_addr_q <= bus.host_a1 ? addr1_q : addr0_q;
        cap_din_q  <= bus.host_din;
      end
      if (state_q == ST_DECODE) begin
        dec_kind_q <= dec_kind_d;
        dec_idx_q  <= dec_idx_d;
      end
    end
  end

  // Register storage, written once per accepted data write in COMMIT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_OPS; i++)   op_q[i] <= '0;
      for (int unsigned i = 0; i < NUM_CHANS; i++) ch_q[i] <= '0;
      new_q <= 1'b0;
      dvb_q <= 1'b0;
    end else if (state_q == ST_COMMIT) begin
      case (dec_kind_q)
        DK_OP_AM: begin
          op_q[dec_idx_q].vib  <= cap_din_q[6];
          op_q[dec_idx_q].mult <= cap_din_q[3:0];
        end
        DK_OP_WS: op_q[dec_idx_q].ws <= new_q ? cap_din_q[2:0] : {1'b0, cap_din_q[1:0]};
        DK_CH_A:  ch_q[CHAN_W'(dec_idx_q)].fnum[7:0] <= cap_din_q;
        DK_CH_B: begin
          ch_q[CHAN_W'(dec_idx_q)].block     <= cap_din_q[4:2];
          ch_q[CHAN_W'(dec_idx_q)].fnum[9:8] <= cap_din_q[1:0];
        end
        DK_DVB:   dvb_q <= cap_din_q[6];
        DK_NEW:   new_q <= cap_din_q[0];
        default:  ;
      endcase
    end
  end

  // Registered read port; out-of-range slots read as zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fnum_q  <= '0;
      block_q <= '0;
      mult_q  <= '0;
      ws_q    <= '0;
      vib_q   <= 1'b0;
    end else if (bus.op_sel < SLOT_W'(NUM_OPS)) begin
      fnum_q  <= ch_q[rd_chan_c].fnum;
      block_q <= ch_q[rd_chan_c].block;
      mult_q  <= op_q[bus.op_sel].mult;
      ws_q    <= op_q[bus.op_sel].ws;
      vib_q   <= op_q[bus.op_sel].vib;
    end else begin
      fnum_q  <= '0;
      block_q <= '0;
      mult_q  <= '0;
      ws_q    <= '0;
      vib_q   <= 1'b0;
    end
  end

  assign bus.host_busy = busy_q;
  assign bus.host_drop = drop_q;
  assign bus.fnum      = fnum_q;
  assign bus.block     = block_q;
  assign bus.mult      = mult_q;
  assign bus.ws        = ws_q;
  assign bus.vib       = vib_q;
  assign bus.dvb       = dvb_q;

endmodule

// File: tb/tb_opl3_reg_decode.sv
// Self-checking bench for opl3_reg_decode against an array-based register model.
module tb_opl3_reg_decode;
  import opl3_pkg::*;

  localparam int unsigned BUSY = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  opl3_reg_decode_if bus();

  opl3_reg_decode #(.BUSY_CYCLES(BUSY)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference register file
  int m_vib [36];
  int m_mult[36];
  int m_ws  [36];
  int m_fnum [18];
  int m_block[18];
  int m_dvb;
  int m_new;

  function automatic void model_reset();
    for (int i = 0; i < 36; i++) begin
      m_vib[i] = 0; m_mult[i] = 0; m_ws[i] = 0;
    end
    for (int i = 0; i < 18; i++) begin
      m_fnum[i] = 0; m_block[i] = 0;
    end
    m_dvb = 0;
    m_new = 0;
  endfunction

  function automatic void model_write(int bank, int addr, int din);
    int o, slot, ch;
    if ((addr >= 'h20 && addr <= 'h35) || (addr >= 'hE0 && addr <= 'hF5)) begin
      o = addr % 32;
      if (o <= 21 && (o % 8) < 6) begin
        slot = bank * 18 + (o / 8) * 6 + (o % 8);
        if (addr < 'h80) begin
          m_vib[slot]  = (din / 64) % 2;
          m_mult[slot] = din % 16;
        end else begin
          m_ws[slot] = (m_new != 0) ? din % 8 : din % 4;
        end
      end
    end else if (addr >= 'hA0 && addr <= 'hA8) begin
      ch = bank * 9 + (addr - 'hA0);
      m_fnum[ch] = (m_fnum[ch] / 256) * 256 + din;
    end else if (addr >= 'hB0 && addr <= 'hB8) begin
      ch = bank * 9 + (addr - 'hB0);
      m_block[ch] = (din / 4) % 8;
      m_fnum[ch]  = (din % 4) * 256 + (m_fnum[ch] % 256);
    end else if (bank == 0 && addr == 'hBD) begin
      m_dvb = (din / 64) % 2;
    end else if (bank == 1 && addr == 'h05) begin
      m_new = din % 2;
    end
  endfunction

  // Expected {fnum, block, mult, ws, vib} for a read of op_sel = slot
  function automatic logic [20:0] exp_fields(int slot);
    int ch;
    logic [20:0] r;
    r = '0;
    if (slot <= 35) begin
      ch = (slot / 18) * 9 + ((slot % 18) / 6) * 3 + ((slot % 18) % 6) % 3;
      r = {10'(m_fnum[ch]), 3'(m_block[ch]), 4'(m_mult[slot]), 3'(m_ws[slot]), 1'(m_vib[slot])};
    end
    return r;
  endfunction

  task automatic strobe(input int bank, input int a0, input int din);
    @(negedge clk);
    bus.host_wr  = 1'b1;
    bus.host_a0  = 1'(a0);
    bus.host_a1  = 1'(bank);
    bus.host_din = 8'(din);
    @(negedge clk);
    bus.host_wr  = 1'b0;
  endtask

  // Counts negedges with busy high, starting at the current one
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.host_busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout got=%0d required<40", n);
    end
  endtask

  task automatic host_write(input int bank, input int addr, input int din, output int busy_n);
    strobe(bank, 0, addr);
    strobe(bank, 1, din);
    wait_idle(busy_n);
    model_write(bank, addr, din);
  endtask

  task automatic read_op(input int slot, output logic [20:0] f);
    @(negedge clk);
    bus.op_sel = 6'(slot);
    @(negedge clk);
    f = {bus.fnum, bus.block, bus.mult, bus.ws, bus.vib};
  endtask

  task automatic test_reset();
    logic [20:0] f;
    bus.host_wr = 1'b0; bus.host_a0 = 1'b0; bus.host_a1 = 1'b0;
    bus.host_din = '0; bus.op_sel = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.host_busy !== 1'b0 || bus.host_drop !== 1'b0 || bus.dvb !== 1'b0) begin
      failures++;
      $display("FAIL reset_status got=%b%b%b exp=000", bus.host_busy, bus.host_drop, bus.dvb);
    end
    for (int s = 0; s < 36; s++) begin
      read_op(s, f);
      checks++;
      if (f !== 21'd0) begin
        failures++;
        $display("FAIL reset_fields slot=%0d got=%h exp=0", s, f);
      end
    end
  endtask

  task automatic test_op_mult();
    int n;
    logic [20:0] f;
    strobe(0, 0, 'h20);
    checks++;
    if (bus.host_busy !== 1'b0) begin
      failures++;
      $display("FAIL addr_no_busy got=%b exp=0", bus.host_busy);
    end
    strobe(0, 1, 'h47);
    wait_idle(n);
    model_write(0, 'h20, 'h47);
    checks++;
    if (n != 2 + BUSY) begin
      failures++;
      $display("FAIL busy_len got=%0d exp=%0d", n, 2 + BUSY);
    end
    host_write(0, 'h60, 'h55, n);
    checks++;
    if (n != 2 + BUSY) begin
      failures++;
      $display("FAIL busy_len_ignored got=%0d exp=%0d", n, 2 + BUSY);
    end
    read_op(0, f);
    checks++;
    if (bus.vib !== 1'b1 || bus.mult !== 4'd7 || f !== exp_fields(0)) begin
      failures++;
      $display("FAIL op_mult got=%h exp=%h", f, exp_fields(0));
    end
  endtask

  task automatic test_channel();
    int n;
    logic [20:0] f;
    host_write(1, 'hA5, 'h34, n);
    host_write(1, 'hB5, 'h16, n);
    foreach (f[i]) ;
    for (int k = 0; k < 2; k++) begin
      read_op((k == 0) ? 26 : 29, f);
      checks++;
      if (bus.fnum !== 10'h234 || bus.block !== 3'd5) begin
        failures++;
        $display("FAIL chan14 k=%0d got=%h/%0d exp=234/5", k, bus.fnum, bus.block);
      end
    end
    for (int k = 0; k < 2; k++) begin
      read_op((k == 0) ? 32 : 20, f);
      checks++;
      if (f !== exp_fields((k == 0) ? 32 : 20)) begin
        failures++;
        $display("FAIL chan_other k=%0d got=%h exp=%h", k, f, exp_fields((k == 0) ? 32 : 20));
      end
    end
  endtask

  task automatic test_ws_new();
    int n;
    logic [20:0] f;
    host_write(0, 'hE0, 'h07, n);
    read_op(0, f);
    checks++;
    if (bus.ws !== 3'd3) begin
      failures++;
      $display("FAIL ws_old_mode got=%0d exp=3", bus.ws);
    end
    host_write(1, 'h05, 'h01, n);
    host_write(0, 'hE0, 'h07, n);
    read_op(0, f);
    checks++;
    if (bus.ws !== 3'd7 || f !== exp_fields(0)) begin
      failures++;
      $display("FAIL ws_new_mode got=%0d exp=7", bus.ws);
    end
  endtask

  task automatic test_invalid_and_drop();
    int n;
    logic [20:0] f;
    host_write(0, 'h26, 'hFF, n);
    checks++;
    if (n != 2 + BUSY) begin
      failures++;
      $display("FAIL busy_len_invalid got=%0d exp=%0d", n, 2 + BUSY);
    end
    for (int s = 0; s < 36; s++) begin
      read_op(s, f);
      checks++;
      if (f !== exp_fields(s)) begin
        failures++;
        $display("FAIL invalid_off slot=%0d got=%h exp=%h", s, f, exp_fields(s));
      end
    end
    strobe(0, 0, 'h21);
    strobe(0, 1, 'h11);
    strobe(0, 1, 'h0F);
    checks++;
    if (bus.host_drop !== 1'b1) begin
      failures++;
      $display("FAIL drop_pulse got=%b exp=1", bus.host_drop);
    end
    @(negedge clk);
    checks++;
    if (bus.host_drop !== 1'b0) begin
      failures++;
      $display("FAIL drop_one_cycle got=%b exp=0", bus.host_drop);
    end
    checks++;
    if (bus.host_busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_during_hold got=%b exp=1", bus.host_busy);
    end
    strobe(0, 0, 'h22);
    wait_idle(n);
    model_write(0, 'h21, 'h11);
    strobe(0, 1, 'h4A);
    wait_idle(n);
    model_write(0, 'h22, 'h4A);
    for (int s = 1; s <= 2; s++) begin
      read_op(s, f);
      checks++;
      if (f !== exp_fields(s)) begin
        failures++;
        $display("FAIL drop_store slot=%0d got=%h exp=%h", s, f, exp_fields(s));
      end
    end
  endtask

  task automatic test_commit_read();
    int n;
    int old_mult;
    old_mult = m_mult[3];
    strobe(0, 0, 'h23);
    bus.op_sel = 6'd3;
    strobe(0, 1, 'h09);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (32'(bus.mult) != old_mult) begin
      failures++;
      $display("FAIL commit_read_old got=%0d exp=%0d", bus.mult, old_mult);
    end
    @(negedge clk);
    checks++;
    if (bus.mult !== 4'd9) begin
      failures++;
      $display("FAIL commit_read_new got=%0d exp=9", bus.mult);
    end
    wait_idle(n);
    model_write(0, 'h23, 'h09);
  endtask

  task automatic test_reset_mid();
    int n;
    logic [20:0] f;
    strobe(0, 0, 'hBD);
    strobe(0, 1, 'h40);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.host_busy !== 1'b0 || bus.dvb !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got=busy%b dvb%b exp=00", bus.host_busy, bus.dvb);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.dvb !== 1'b0 || bus.host_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_after got=dvb%b busy%b exp=00", bus.dvb, bus.host_busy);
    end
    read_op(0, f);
    checks++;
    if (f !== 21'd0) begin
      failures++;
      $display("FAIL reset_mid_storage got=%h exp=0", f);
    end
    host_write(0, 'hBD, 'h40, n);
    checks++;
    if (bus.dvb !== 1'b1) begin
      failures++;
      $display("FAIL dvb_rewrite got=%b exp=1", bus.dvb);
    end
  endtask

  task automatic test_random();
    int n, bank, addr, din, slot;
    logic [20:0] f;
    for (int it = 0; it < 150; it++) begin
      bank = int'($urandom_range(0, 1));
      din  = int'($urandom_range(0, 255));
      case ($urandom_range(0, 6))
        0:       addr = 'h20 + int'($urandom_range(0, 31));
        1:       addr = 'hE0 + int'($urandom_range(0, 31));
        2:       addr = 'hA0 + int'($urandom_range(0, 15));
        3:       addr = 'hB0 + int'($urandom_range(0, 15));
        4:       addr = 'hBD;
        5:       addr = 'h05;
        default: addr = int'($urandom_range(0, 255));
      endcase
      host_write(bank, addr, din, n);
      checks++;
      if (n != 2 + BUSY) begin
        failures++;
        $display("FAIL rnd_busy it=%0d got=%0d exp=%0d", it, n, 2 + BUSY);
      end
      slot = int'($urandom_range(0, 63));
      read_op(slot, f);
      checks++;
      if (f !== exp_fields(slot) || 32'(bus.dvb) != m_dvb) begin
        failures++;
        $display("FAIL rnd_read it=%0d slot=%0d got=%h/%b exp=%h/%0d",
                 it, slot, f, bus.dvb, exp_fields(slot), m_dvb);
      end
    end
    for (int s = 0; s < 36; s++) begin
      read_op(s, f);
      checks++;
      if (f !== exp_fields(s)) begin
        failures++;
        $display("FAIL rnd_sweep slot=%0d got=%h exp=%h", s, f, exp_fields(s));
      end
    end
  endtask

  initial begin
    test_reset();
    test_op_mult();
    test_channel();
    test_ws_new();
    test_invalid_and_drop();
    test_commit_read();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
